mystic_l1_port_arbiter: RTL and testbench

Shares one L1 memory port between the core's instruction-fetch requester and its load/store requester. Single-cycle request pulses from either side are captured, arbitrated, and issued as held-until-acknowledged transactions. Responses are returned as single-cycle ready pulses with registered data. The block sits between the core's fetch/data interfaces and the unified L1 port.

---
 rtl/mystic_l1_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mystic_l1_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mystic_l1_port_arbiter.sv
// mystic_l1_port_arbiter: shares one L1 memory port between the fetch and load/store requesters.
// Define MYSTIC_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mystic_l1_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [31:0]           if_rdata_o,
    output logic                  if_ready_o,
    input  logic                  d_read_i,
    input  logic                  d_write_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_wstrb_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_ready_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  busy_o,
    output logic                  viol_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_XFER = 2'd1;
    localparam logic [1:0] ST_D_XFER  = 2'd2;

    logic [1:0]        state_r;
    logic              if_vld_r;
    logic [ADDR_W-1:0] if_addr_r;
    logic              d_vld_r;
    logic              d_we_r;
    logic [ADDR_W-1:0] d_addr_r;
    logic [DATA_W-1:0] d_wdata_r;
    logic [STRB_W-1:0] d_wstrb_r;

    logic              mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [STRB_W-1:0] mem_wstrb_r;
    logic              if_ready_r, d_ready_r, busy_r, viol_r;
    logic [31:0]       if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic              d_req_s, if_take_s, d_take_s, viol_s;
    logic              if_cand_s, d_cand_s, issue_s, grant_d_s;
    logic              if_done_s, d_done_s, busy_s;
    logic [ADDR_W-1:0] if_addr_eff_s, d_addr_eff_s;
    logic              d_we_eff_s;
    logic [DATA_W-1:0] d_wdata_eff_s;
    logic [STRB_W-1:0] d_wstrb_eff_s;

`ifdef MYSTIC_ARB_RR_EN
    logic              last_d_r;
`endif

    // Request acceptance, violation detection and winner selection; a request arriving
    // in an IDLE cycle competes immediately so the port is driven on the very next cycle.
    always_comb begin
        d_req_s   = d_read_i | d_write_i;
        if_take_s = if_req_i & ~if_vld_r;
        d_take_s  = d_req_s & ~d_vld_r;
        viol_s    = (if_req_i & if_vld_r) | (d_req_s & d_vld_r) | (d_read_i & d_write_i);
        if_cand_s = if_vld_r | if_take_s;
        d_cand_s  = d_vld_r | d_take_s;
        if (if_vld_r) begin
            if_addr_eff_s = if_addr_r;
        end else begin
            if_addr_eff_s = if_addr_i;
        end
        if (d_vld_r) begin
            d_we_eff_s    = d_we_r;
            d_addr_eff_s  = d_addr_r;
            d_wdata_eff_s = d_wdata_r;
            d_wstrb_eff_s = d_wstrb_r;
        end else begin
            d_we_eff_s    = d_write_i;
            d_addr_eff_s  = d_addr_i;
            d_wdata_eff_s = d_wdata_i;
            d_wstrb_eff_s = d_wstrb_i;
        end
        issue_s   = (state_r == ST_IDLE) & (if_cand_s | d_cand_s);
        if_done_s = (state_r == ST_IF_XFER) & mem_ack_i;
        d_done_s  = (state_r == ST_D_XFER) & mem_ack_i;
`ifdef MYSTIC_ARB_RR_EN
        grant_d_s = d_cand_s & (~if_cand_s | ~last_d_r);
`else
        grant_d_s = d_cand_s;
`endif
        busy_s    = (if_vld_r & ~if_done_s) | if_take_s | (d_vld_r & ~d_done_s) | d_take_s;
    end

    // Pending slots: loaded by an accepted pulse, cleared by the acknowledge of their transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_vld_r  <= 1'b0;
            if_addr_r <= '0;
            d_vld_r   <= 1'b0;
            d_we_r    <= 1'b0;
            d_addr_r  <= '0;
            d_wdata_r <= '0;
            d_wstrb_r <= '0;
        end else begin
            if (if_done_s) begin
                if_vld_r <= 1'b0;
            end else if (if_take_s) begin
                if_vld_r  <= 1'b1;
                if_addr_r <= if_addr_i;
            end
            if (d_done_s) begin
                d_vld_r <= 1'b0;
            end else if (d_take_s) begin
                d_vld_r   <= 1'b1;
                d_we_r    <= d_write_i;
                d_addr_r  <= d_addr_i;
                d_wdata_r <= d_wdata_i;
                d_wstrb_r <= d_wstrb_i;
            end
        end
    end

    // Port FSM: issue from IDLE, hold every mem_* output stable until acknowledged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s && grant_d_s) begin
                        state_r     <= ST_D_XFER;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= d_we_eff_s;
                        mem_addr_r  <= d_addr_eff_s;
                        mem_wdata_r <= d_wdata_eff_s;
                        mem_wstrb_r <= d_we_eff_s ? d_wstrb_eff_s : {STRB_W{1'b0}};
                    end else if (issue_s) begin
                        state_r     <= ST_IF_XFER;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= if_addr_eff_s;
                        mem_wstrb_r <= '0;
                    end
                end
                ST_IF_XFER, ST_D_XFER: begin
                    if (mem_ack_i) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MYSTIC_ARB_RR_EN
    // Last-grant pointer; resets to fetch-last so the first collision goes to data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_d_r <= 1'b0;
        end else if (issue_s) begin
            last_d_r <= grant_d_s;
        end
    end
`endif

    // Response pulses, returned data and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_ready_r <= 1'b0;
            d_ready_r  <= 1'b0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
            busy_r     <= 1'b0;
            viol_r     <= 1'b0;
        end else begin
            if_ready_r <= if_done_s;
            d_ready_r  <= d_done_s;
            busy_r     <= busy_s;
            viol_r     <= viol_s;
            if (if_done_s) begin
                if_rdata_r <= if_addr_r[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end
            if (d_done_s && !d_we_r) begin
                d_rdata_r <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign mem_wstrb_o = mem_wstrb_r;
    assign if_ready_o  = if_ready_r;
    assign if_rdata_o  = if_rdata_r;
    assign d_ready_o   = d_ready_r;
    assign d_rdata_o   = d_rdata_r;
    assign busy_o      = busy_r;
    assign viol_o      = viol_r;
endmodule

// File: tb/tb_mystic_l1_port_arbiter.sv
// Testbench for mystic_l1_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the port-sharing rules.
module tb_mystic_l1_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        d_read_i = 1'b0;
    logic        d_write_i = 1'b0;
    logic [31:0] d_addr_i = 32'h0;
    logic [63:0] d_wdata_i = 64'h0;
    logic [7:0]  d_wstrb_i = 8'h0;
    logic [63:0] d_rdata_o;
    logic        d_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic [63:0] mem_rdata_i = 64'h0;
    logic        mem_ack_i = 1'b0;
    logic        busy_o;
    logic        viol_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] last_load;

    // Reference model state: pending requests, port owner (0 none, 1 fetch, 2 data)
    logic        mf_v, md_v, md_we;
    logic [31:0] mf_addr, md_addr;
    logic [63:0] md_wdata;
    logic [7:0]  md_wstrb;
    int          m_port;
`ifdef MYSTIC_ARB_RR_EN
    logic        m_last_d;
`endif
    logic        exp_req, exp_we, exp_if_ready, exp_d_ready, exp_busy, exp_viol;
    logic [31:0] exp_addr, exp_if_rdata;
    logic [63:0] exp_wdata, exp_d_rdata;
    logic [7:0]  exp_wstrb;

    mystic_l1_port_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .viol_o(viol_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i  = 1'b0;
        d_read_i  = 1'b0;
        d_write_i = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, if_ready_o, if_rdata_o,
             d_ready_o, d_rdata_o, busy_o, viol_o} !== 206'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h ws=%h ifr=%b ifd=%h dr=%b dd=%h busy=%b viol=%b, want all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, if_ready_o, if_rdata_o,
                     d_ready_o, d_rdata_o, busy_o, viol_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        if_req_i = 1'b1;
        if_addr_i = 32'h0000_0104;
        step();
        if_req_i = 1'b0;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, busy_o} !== {1'b1, 1'b0, 32'h0000_0104, 1'b1}) begin
            n_fail++;
            $display("FAIL fetch_issue: req=%b we=%b addr=%h busy=%b, want 1 0 00000104 1", mem_req_o, mem_we_o, mem_addr_o, busy_o);
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({if_ready_o, if_rdata_o, mem_req_o} !== {1'b1, 32'hAAAA_BBBB, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_response: ready=%b data=%h req=%b, want 1 aaaabbbb 0", if_ready_o, if_rdata_o, mem_req_o);
        end
        step();
        n_checks++;
        if ({if_ready_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_after: ready=%b busy=%b, want 0 0", if_ready_o, busy_o);
        end
    endtask

    task automatic test_collision();
        logic [31:0] fa, da;
        logic [63:0] rd;
        for (int r = 0; r < 2; r++) begin
            fa = 32'h0000_1000 + 32'(r * 16);
            da = 32'h0000_2008 + 32'(r * 16);
            rd = 64'h0123_4567_89AB_CDEF + 64'(r);
            if_req_i = 1'b1; if_addr_i = fa;
            d_read_i = 1'b1; d_addr_i = da;
            step();
            idle_inputs();
            n_checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o} !== {1'b1, 1'b0, da, 8'h00}) begin
                n_fail++;
                $display("FAIL collision_first_grant r%0d: req=%b we=%b addr=%h ws=%h, want 1 0 %h 00", r, mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, da);
            end
            mem_ack_i = 1'b1; mem_rdata_i = rd;
            step();
            mem_ack_i = 1'b0;
            n_checks++;
            if ({d_ready_o, d_rdata_o, mem_req_o} !== {1'b1, rd, 1'b0}) begin
                n_fail++;
                $display("FAIL collision_load_resp r%0d: ready=%b data=%h req=%b, want 1 %h 0", r, d_ready_o, d_rdata_o, mem_req_o, rd);
            end
            last_load = rd;
            step();
            n_checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, fa}) begin
                n_fail++;
                $display("FAIL collision_second_grant r%0d: req=%b we=%b addr=%h, want 1 0 %h", r, mem_req_o, mem_we_o, mem_addr_o, fa);
            end
            mem_ack_i = 1'b1; mem_rdata_i = 64'hFEDC_BA98_7654_3210;
            step();
            mem_ack_i = 1'b0;
            n_checks++;
            if ({if_ready_o, if_rdata_o} !== {1'b1, 32'h7654_3210}) begin
                n_fail++;
                $display("FAIL collision_fetch_resp r%0d: ready=%b data=%h, want 1 76543210", r, if_ready_o, if_rdata_o);
            end
            step();
        end
    endtask

    task automatic test_store();
        d_write_i = 1'b1; d_addr_i = 32'h0000_0200; d_wdata_i = 64'h11; d_wstrb_i = 8'h01;
        step();
        d_write_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o} !==
                {1'b1, 1'b1, 32'h0000_0200, 64'h11, 8'h01, 1'b1}) begin
                n_fail++;
                $display("FAIL store_hold c%0d: req=%b we=%b addr=%h wd=%h ws=%h busy=%b, want 1 1 00000200 11 01 1",
                         c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o);
            end
            mem_ack_i = (c == 4);
            mem_rdata_i = 64'hDEAD_BEEF_0000_0001;
            step();
        end
        mem_ack_i = 1'b0;
        n_checks++;
        if ({d_ready_o, d_rdata_o, mem_req_o} !== {1'b1, last_load, 1'b0}) begin
            n_fail++;
            $display("FAIL store_resp: ready=%b data=%h req=%b, want 1 %h 0", d_ready_o, d_rdata_o, mem_req_o, last_load);
        end
        step();
        n_checks++;
        if (d_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ready_pulse: ready=%b, want 0", d_ready_o);
        end
    endtask

    task automatic test_violation();
        int txn;
        d_read_i = 1'b1; d_addr_i = 32'h0000_0300;
        step();
        d_addr_i = 32'h0000_0308;
        n_checks++;
        if ({mem_req_o, mem_addr_o, viol_o} !== {1'b1, 32'h0000_0300, 1'b0}) begin
            n_fail++;
            $display("FAIL viol_first: req=%b addr=%h viol=%b, want 1 00000300 0", mem_req_o, mem_addr_o, viol_o);
        end
        step();
        d_read_i = 1'b0;
        n_checks++;
        if ({viol_o, mem_addr_o} !== {1'b1, 32'h0000_0300}) begin
            n_fail++;
            $display("FAIL viol_pulse: viol=%b addr=%h, want 1 00000300", viol_o, mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
        step();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({viol_o, d_ready_o, d_rdata_o} !== {1'b0, 1'b1, 64'h5555_6666_7777_8888}) begin
            n_fail++;
            $display("FAIL viol_resp: viol=%b ready=%b data=%h, want 0 1 5555666677778888", viol_o, d_ready_o, d_rdata_o);
        end
        txn = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (mem_req_o) txn++;
        end
        n_checks++;
        if (txn !== 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL viol_single_txn: extra req cycles=%0d busy=%b, want 0 0", txn, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        d_write_i = 1'b1; d_addr_i = 32'h0000_0400; d_wdata_i = 64'h99; d_wstrb_i = 8'hFF;
        step();
        d_write_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, if_ready_o, if_rdata_o,
             d_ready_o, d_rdata_o, busy_o, viol_o} !== 206'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: req=%b we=%b addr=%h dr=%b dd=%h busy=%b, want all 0",
                     mem_req_o, mem_we_o, mem_addr_o, d_ready_o, d_rdata_o, busy_o);
        end
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if ({d_ready_o, mem_req_o, busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_stray_ack c%0d: ready=%b req=%b busy=%b, want 0 0 0", c, d_ready_o, mem_req_o, busy_o);
            end
            step();
        end
    endtask

    task automatic model_reset();
        mf_v = 1'b0; md_v = 1'b0; md_we = 1'b0;
        mf_addr = 32'h0; md_addr = 32'h0; md_wdata = 64'h0; md_wstrb = 8'h0;
        m_port = 0;
`ifdef MYSTIC_ARB_RR_EN
        m_last_d = 1'b0;
`endif
        exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 64'h0; exp_wstrb = 8'h0;
        exp_if_ready = 1'b0; exp_if_rdata = 32'h0; exp_d_ready = 1'b0; exp_d_rdata = 64'h0;
        exp_busy = 1'b0; exp_viol = 1'b0;
    endtask

    // Applies one cycle's inputs to the model and produces next-cycle expectations.
    task automatic model_cycle();
        logic dreq, pick_d;
        dreq = d_read_i | d_write_i;
        exp_viol = (if_req_i && mf_v) || (dreq && md_v) || (d_read_i && d_write_i);
        exp_if_ready = 1'b0;
        exp_d_ready = 1'b0;
        if (if_req_i && !mf_v) begin
            mf_v = 1'b1; mf_addr = if_addr_i;
        end
        if (dreq && !md_v) begin
            md_v = 1'b1; md_we = d_write_i; md_addr = d_addr_i; md_wdata = d_wdata_i; md_wstrb = d_wstrb_i;
        end
        if (m_port != 0) begin
            if (mem_ack_i) begin
                if (m_port == 1) begin
                    exp_if_ready = 1'b1;
                    exp_if_rdata = mf_addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                    mf_v = 1'b0;
                end else begin
                    exp_d_ready = 1'b1;
                    if (!md_we) exp_d_rdata = mem_rdata_i;
                    md_v = 1'b0;
                end
                m_port = 0;
                exp_req = 1'b0;
            end
        end else if (mf_v || md_v) begin
`ifdef MYSTIC_ARB_RR_EN
            pick_d = md_v && (!mf_v || !m_last_d);
            m_last_d = pick_d;
`else
            pick_d = md_v;
`endif
            exp_req = 1'b1;
            if (pick_d) begin
                m_port = 2; exp_we = md_we; exp_addr = md_addr; exp_wdata = md_wdata;
                exp_wstrb = md_we ? md_wstrb : 8'h00;
            end else begin
                m_port = 1; exp_we = 1'b0; exp_addr = mf_addr; exp_wstrb = 8'h00;
            end
        end
        exp_busy = mf_v || md_v;
    endtask

    task automatic test_random();
        int k;
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if_req_i = ($urandom_range(0, 2) == 0);
            if_addr_i = $urandom;
            k = $urandom_range(0, 5);
            d_read_i = (k == 0) || (k == 2);
            d_write_i = (k == 1) || (k == 2);
            d_addr_i = $urandom;
            d_wdata_i = {$urandom, $urandom};
            d_wstrb_i = 8'($urandom_range(0, 255));
            mem_rdata_i = {$urandom, $urandom};
            mem_ack_i = mem_req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            model_cycle();
            step();
            n_checks++;
            if ({mem_req_o, if_ready_o, d_ready_o, busy_o, viol_o} !== {exp_req, exp_if_ready, exp_d_ready, exp_busy, exp_viol}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc%0d: req/ifr/dr/busy/viol=%b, want %b", cyc,
                         {mem_req_o, if_ready_o, d_ready_o, busy_o, viol_o}, {exp_req, exp_if_ready, exp_d_ready, exp_busy, exp_viol});
            end
            n_checks++;
            if ({if_rdata_o, d_rdata_o} !== {exp_if_rdata, exp_d_rdata}) begin
                n_fail++;
                $display("FAIL rand_rdata cyc%0d: if=%h d=%h, want if=%h d=%h", cyc, if_rdata_o, d_rdata_o, exp_if_rdata, exp_d_rdata);
            end
            if (exp_req) begin
                n_checks++;
                if ({mem_we_o, mem_addr_o, mem_wstrb_o} !== {exp_we, exp_addr, exp_wstrb}) begin
                    n_fail++;
                    $display("FAIL rand_port cyc%0d: we=%b addr=%h ws=%h, want %b %h %h", cyc, mem_we_o, mem_addr_o, mem_wstrb_o, exp_we, exp_addr, exp_wstrb);
                end
                if (exp_we) begin
                    n_checks++;
                    if (mem_wdata_o !== exp_wdata) begin
                        n_fail++;
                        $display("FAIL rand_wdata cyc%0d: wdata=%h, want %h", cyc, mem_wdata_o, exp_wdata);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        last_load = 64'h0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_store();
        test_violation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
